// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I/M decode stage: opcodes, select codes,
// ALU operation codes, the ID/EX control bundle and the M-op FSM states.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_MD  = 2'b11;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MD_RUN = 1'b1
    } md_state_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic       alu_src_a;
        logic       illegal;
        logic       md_op;
        logic [1:0] result_src;
        logic [3:0] alu_ctrl;
        logic [2:0] md_funct;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct3/funct7 decode into the ALU operation code,
// with legality checking of every supported encoding.
module alu_ctrl_decode
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_alu_ctrl,
    output logic       o_md_op,
    output logic       o_illegal
);

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [3:0] w_alu;
    logic       w_md;
    logic       w_ill;

    always_comb begin
        w_alu = ALU_ADD;
        w_md  = 1'b0;
        w_ill = 1'b0;
        case (i_opcode)
            OP_R: begin
                if (i_funct7 == 7'b0000001) begin
                    w_md  = ENABLE_M;
                    w_ill = !ENABLE_M;
                end else if (i_funct7 == 7'b0000000) begin
                    w_alu = arith_op(i_funct3, 1'b0);
                end else if (i_funct7 == 7'b0100000 &&
                             (i_funct3 == 3'b000 || i_funct3 == 3'b101)) begin
                    w_alu = arith_op(i_funct3, 1'b1);
                end else begin
                    w_ill = 1'b1;
                end
            end
            // Only SRAI reuses imm[10] as an operation selector; shifts must
            // carry a clean upper immediate field.
            OP_IMM: begin
                w_alu = arith_op(i_funct3, (i_funct3 == 3'b101) && i_funct7[5]);
                if (i_funct3 == 3'b001 && i_funct7 != 7'b0000000)
                    w_ill = 1'b1;
                if (i_funct3 == 3'b101 && i_funct7 != 7'b0000000 &&
                    i_funct7 != 7'b0100000)
                    w_ill = 1'b1;
            end
            OP_LOAD:   w_ill = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                               (i_funct3 == 3'b111);
            OP_STORE:  w_ill = i_funct3[2] || (i_funct3 == 3'b011);
            OP_BRANCH: begin
                w_alu = ALU_SUB;
                w_ill = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
            end
            OP_JALR:   w_ill = (i_funct3 != 3'b000);
            OP_JAL:    w_alu = ALU_ADD;
            OP_AUIPC:  w_alu = ALU_ADD;
            OP_LUI:    w_alu = ALU_PASSB;
            default:   w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_alu = ALU_ADD;
            w_md  = 1'b0;
        end
    end

    assign o_alu_ctrl = w_alu;
    assign o_md_op    = w_md;
    assign o_illegal  = w_ill;

endmodule

// File: rtl/decode_ctrl_stage.sv
// RV32I(+M) decode stage: control decode, ID/EX control register with
// hazard stall/flush, and the multi-cycle MUL/DIV occupancy FSM.
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic        stall_e,
    input  logic        flush_e,
    output logic [2:0]  imm_src_d,
    output logic        valid_e,
    output logic        reg_write_e,
    output logic        mem_write_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic        jalr_e,
    output logic        alu_src_e,
    output logic        alu_src_a_e,
    output logic        illegal_e,
    output logic        md_op_e,
    output logic [1:0]  result_src_e,
    output logic [3:0]  alu_ctrl_e,
    output logic [2:0]  md_funct_e,
    output logic        md_stall,
    output logic        md_done
);

    function automatic logic [4:0] md_cycles(input logic sel_div);
        return sel_div ? 5'(DIV_CYCLES) : 5'(MUL_CYCLES);
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [3:0] w_alu_ctrl;
    logic       w_md_op;
    logic       w_illegal;
    logic       w_unused;
    ctrl_t      w_ctrl_d;
    ctrl_t      r_ctrl_e;
    logic       w_load;
    logic [4:0] w_cycles_d;
    md_state_e  r_state, w_state_nx;
    logic [3:0] r_cnt, w_cnt_nx;
    logic       r_md_done, w_md_done_nx;

    assign w_opcode = instr_d[6:0];
    assign w_funct3 = instr_d[14:12];
    assign w_funct7 = instr_d[31:25];
    assign w_unused = ^{instr_d[24:15], instr_d[11:7]};

    alu_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_alu_ctrl_decode (
        .i_opcode   (w_opcode),
        .i_funct3   (w_funct3),
        .i_funct7   (w_funct7),
        .o_alu_ctrl (w_alu_ctrl),
        .o_md_op    (w_md_op),
        .o_illegal  (w_illegal)
    );

    always_comb begin
        w_ctrl_d  = '0;
        imm_src_d = IMM_I;
        case (w_opcode)
            OP_STORE:          imm_src_d = IMM_S;
            OP_BRANCH:         imm_src_d = IMM_B;
            OP_JAL:            imm_src_d = IMM_J;
            OP_LUI, OP_AUIPC:  imm_src_d = IMM_U;
            default:           imm_src_d = IMM_I;
        endcase
        // A bubble (valid_d=0) leaves the whole bundle zero.
        if (valid_d) begin
            w_ctrl_d.valid = 1'b1;
            if (w_illegal) begin
                w_ctrl_d.illegal = 1'b1;
            end else begin
                w_ctrl_d.alu_ctrl = w_alu_ctrl;
                case (w_opcode)
                    OP_LOAD: begin
                        w_ctrl_d.reg_write  = 1'b1;
                        w_ctrl_d.alu_src    = 1'b1;
                        w_ctrl_d.result_src = RES_MEM;
                    end
                    OP_STORE: begin
                        w_ctrl_d.mem_write = 1'b1;
                        w_ctrl_d.alu_src   = 1'b1;
                    end
                    OP_R: begin
                        w_ctrl_d.reg_write = 1'b1;
                        if (w_md_op) begin
                            w_ctrl_d.md_op      = 1'b1;
                            w_ctrl_d.result_src = RES_MD;
                            w_ctrl_d.md_funct   = w_funct3;
                        end
                    end
                    OP_IMM: begin
                        w_ctrl_d.reg_write = 1'b1;
                        w_ctrl_d.alu_src   = 1'b1;
                    end
                    OP_BRANCH: w_ctrl_d.branch = 1'b1;
                    OP_JAL: begin
                        w_ctrl_d.reg_write  = 1'b1;
                        w_ctrl_d.jump       = 1'b1;
                        w_ctrl_d.result_src = RES_PC4;
                    end
                    OP_JALR: begin
                        w_ctrl_d.reg_write  = 1'b1;
                        w_ctrl_d.jump       = 1'b1;
                        w_ctrl_d.jalr       = 1'b1;
                        w_ctrl_d.alu_src    = 1'b1;
                        w_ctrl_d.result_src = RES_PC4;
                    end
                    OP_LUI: begin
                        w_ctrl_d.reg_write = 1'b1;
                        w_ctrl_d.alu_src   = 1'b1;
                    end
                    OP_AUIPC: begin
                        w_ctrl_d.reg_write = 1'b1;
                        w_ctrl_d.alu_src   = 1'b1;
                        w_ctrl_d.alu_src_a = 1'b1;
                    end
                    default: w_ctrl_d.illegal = 1'b1;
                endcase
            end
        end
    end

    assign md_stall   = (r_state == ST_MD_RUN);
    assign w_load     = !flush_e && !stall_e && !md_stall;
    assign w_cycles_d = md_cycles(w_funct3[2]);

    // ---- ID/EX boundary ----
    always_ff @(posedge clk) begin
        if (rst)
            r_ctrl_e <= '0;
        else if (flush_e)
            r_ctrl_e <= '0;
        else if (w_load)
            r_ctrl_e <= w_ctrl_d;
    end

    // The counter starts at C-2 so that it reaches zero in cycle C-1; md_done
    // is registered and therefore shows up in cycle C, once the stall drops.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_md_done_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load && w_ctrl_d.md_op) begin
                    if (w_cycles_d > 5'd1) begin
                        w_state_nx = ST_MD_RUN;
                        w_cnt_nx   = 4'(w_cycles_d - 5'd2);
                    end else begin
                        w_md_done_nx = 1'b1;
                    end
                end
            end
            ST_MD_RUN: begin
                if (flush_e) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_state_nx   = ST_IDLE;
                    w_md_done_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_md_done <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_md_done <= w_md_done_nx;
        end
    end

    assign md_done      = r_md_done;
    assign valid_e      = r_ctrl_e.valid;
    assign reg_write_e  = r_ctrl_e.reg_write;
    assign mem_write_e  = r_ctrl_e.mem_write;
    assign branch_e     = r_ctrl_e.branch;
    assign jump_e       = r_ctrl_e.jump;
    assign jalr_e       = r_ctrl_e.jalr;
    assign alu_src_e    = r_ctrl_e.alu_src;
    assign alu_src_a_e  = r_ctrl_e.alu_src_a;
    assign illegal_e    = r_ctrl_e.illegal;
    assign md_op_e      = r_ctrl_e.md_op;
    assign result_src_e = r_ctrl_e.result_src;
    assign alu_ctrl_e   = r_ctrl_e.alu_ctrl;
    assign md_funct_e   = r_ctrl_e.md_funct;

endmodule
